// File: rtl/cvrt_pkg.sv
// cvrt_pkg: shared mode enum and one prefix-XOR level for the Gray converter pipe.
package cvrt_pkg;
  typedef enum logic {CVRT_MODE_B2G = 1'b0, CVRT_MODE_G2B = 1'b1} cvrt_mode_e;
  localparam int CVRT_MAX_W = 1024;
  typedef logic [CVRT_MAX_W-1:0] cvrt_word_t;
  // Binary->Gray is only level 0; Gray->binary accumulates every level.
  function automatic cvrt_word_t cvrt_xor_lvl(input cvrt_word_t x, input int k, input cvrt_mode_e mode);
    return (mode == CVRT_MODE_G2B || k == 0) ? x ^ (x >> (1 << k)) : x;
  endfunction
endpackage

// File: rtl/cvrt_gry_stage.sv
// cvrt_gry_stage: one registered slice of the prefix-XOR pipe with stall/flush handshake.
module cvrt_gry_stage
  import cvrt_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4,
  parameter int LVL_LO     = 0,
  parameter int LVL_HI     = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clr,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  cvrt_mode_e            i_mode,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [TAG_WIDTH-1:0]  i_tag,
  output logic                  o_valid,
  input  logic                  i_ready,
  output cvrt_mode_e            o_mode,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [TAG_WIDTH-1:0]  o_tag
);
  logic                  valid_q, valid_d, load;
  cvrt_mode_e            mode_q, mode_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  cvrt_word_t            x;

  always_comb begin
    x = cvrt_word_t'(i_data);
    for (int k = LVL_LO; k < LVL_HI; k++) x = cvrt_xor_lvl(x, k, i_mode);
    o_ready = ~i_clr & (~valid_q | i_ready);
    load    = i_valid & o_ready;
    valid_d = i_clr ? 1'b0 : (o_ready ? i_valid : valid_q);
    data_d  = load ? x[DATA_WIDTH-1:0] : data_q;
    tag_d   = load ? i_tag : tag_q;
    mode_d  = load ? i_mode : mode_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      tag_q   <= '0;
      mode_q  <= CVRT_MODE_B2G;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
      mode_q  <= mode_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_tag   = tag_q;
  assign o_mode  = mode_q;
endmodule

// File: rtl/cvrt_gry_pipe.sv
// cvrt_gry_pipe: pipelined bidirectional binary<->Gray converter with valid/ready handshake.
module cvrt_gry_pipe
  import cvrt_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_WIDTH   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clr,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  cvrt_mode_e            i_mode,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [TAG_WIDTH-1:0]  i_tag,
  output logic                  o_valid,
  input  logic                  i_ready,
  output cvrt_mode_e            o_mode,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [TAG_WIDTH-1:0]  o_tag,
  output logic                  o_busy
);
  localparam int LVL_NUM = $clog2(DATA_WIDTH);

  if (DATA_WIDTH < 2 || DATA_WIDTH >= CVRT_MAX_W || TAG_WIDTH < 1 ||
      PIPE_STAGES < 1 || PIPE_STAGES > LVL_NUM) begin : g_bad_cfg
    $error("cvrt_gry_pipe: illegal DATA_WIDTH/PIPE_STAGES/TAG_WIDTH");
  end

  // Index s is the input side of stage s; index PIPE_STAGES is the block output.
  logic                  v   [PIPE_STAGES+1];
  logic                  rdy [PIPE_STAGES+1];
  cvrt_mode_e            m   [PIPE_STAGES+1];
  logic [DATA_WIDTH-1:0] d   [PIPE_STAGES+1];
  logic [TAG_WIDTH-1:0]  t   [PIPE_STAGES+1];

  assign v[0]             = i_valid;
  assign m[0]             = i_mode;
  assign d[0]             = i_data;
  assign t[0]             = i_tag;
  assign rdy[PIPE_STAGES] = i_ready;

  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
    cvrt_gry_stage #(
      .DATA_WIDTH(DATA_WIDTH),
      .TAG_WIDTH (TAG_WIDTH),
      .LVL_LO    (s * LVL_NUM / PIPE_STAGES),
      .LVL_HI    ((s + 1) * LVL_NUM / PIPE_STAGES)
    ) u_stage (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_clr  (i_clr),
      .i_valid(v[s]),
      .o_ready(rdy[s]),
      .i_mode (m[s]),
      .i_data (d[s]),
      .i_tag  (t[s]),
      .o_valid(v[s+1]),
      .i_ready(rdy[s+1]),
      .o_mode (m[s+1]),
      .o_data (d[s+1]),
      .o_tag  (t[s+1])
    );
  end

  always_comb begin
    o_busy = 1'b0;
    for (int i = 1; i <= PIPE_STAGES; i++) o_busy = o_busy | v[i];
  end

  assign o_ready = rdy[0];
  assign o_valid = v[PIPE_STAGES];
  assign o_mode  = m[PIPE_STAGES];
  assign o_data  = d[PIPE_STAGES];
  assign o_tag   = t[PIPE_STAGES];
endmodule

// File: tb/tb_cvrt_gry_pipe.sv
// tb_cvrt_gry_pipe: scoreboard bench for the 8-bit, 2-stage converter pipe.
module tb_cvrt_gry_pipe;
  import cvrt_pkg::*;

  logic       clk = 1'b0, rst_n = 1'b0, clr = 1'b0, iv = 1'b0, ir = 1'b1;
  cvrt_mode_e im = CVRT_MODE_B2G;
  logic [7:0] id = '0;
  logic [3:0] it = '0;
  logic       o_rdy, ov, busy;
  cvrt_mode_e om;
  logic [7:0] od;
  logic [3:0] ot;

  typedef struct packed {logic [7:0] d; logic [3:0] t; logic m;} exp_t;
  exp_t sb[$];
  int tests = 0, fails = 0, cyc = 0, acc_cyc = 0, out_cyc = 0, first_acc = 0;

  cvrt_gry_pipe #(.DATA_WIDTH(8), .PIPE_STAGES(2), .TAG_WIDTH(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_valid(iv), .o_ready(o_rdy),
    .i_mode(im), .i_data(id), .i_tag(it), .o_valid(ov), .i_ready(ir),
    .o_mode(om), .o_data(od), .o_tag(ot), .o_busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] g2b(input logic [7:0] g);
    logic [7:0] r;
    r[7] = g[7];
    for (int b = 6; b >= 0; b--) r[b] = r[b+1] ^ g[b];
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n && ov && ir) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out: got data 0x%0h tag %0d, expected no output", od, ot);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("data", od, e.d);
        check("tag", ot, e.t);
        check("mode", om, e.m);
        out_cyc = cyc;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic m, input logic [7:0] d, input logic [3:0] t,
                      input logic [7:0] exp, input bit push = 1'b1);
    bit acc = 1'b0;
    iv = 1'b1; im = cvrt_mode_e'(m); id = d; it = t;
    for (int i = 0; i < 40 && !acc; i++) begin
      #2;
      acc = o_rdy;
      if (acc) acc_cyc = cyc;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got o_ready=0 for 40 cycles, expected 1");
    end else if (push) sb.push_back(exp_t'({exp, t, m}));
  endtask

  task automatic drain();
    iv = 1'b0;
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #12;
    check("rst_valid", ov, 0);
    check("rst_ready", o_rdy, 1);
    check("rst_busy", busy, 0);
    check("rst_data", od, 0);
    check("rst_tag", ot, 0);
    check("rst_mode", om, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    // directed conversions with latency
    send(1'b0, 8'h0B, 4'd3, 8'h0E); drain();
    check("latency", out_cyc - acc_cyc, 2);
    send(1'b0, 8'h80, 4'd1, 8'hC0);
    send(1'b1, 8'h0E, 4'd2, 8'h0B);
    send(1'b1, 8'hFF, 4'd4, 8'hAA);
    send(1'b1, 8'h00, 4'd5, 8'h00);
    drain();
    // round trip over every code
    for (int i = 0; i < 256; i++) begin
      logic [7:0] x;
      x = 8'(i);
      send(1'b1, x ^ (x >> 1), x[3:0], x);
    end
    drain();
    // alternating modes back to back
    for (int i = 0; i < 16; i++) begin
      logic [7:0] x;
      x = 8'(i * 37 + 5);
      send(i[0], x, 4'(i), i[0] ? g2b(x) : (x ^ (x >> 1)));
      if (i == 0) first_acc = acc_cyc;
    end
    drain();
    check("b2b_accept_span", acc_cyc - first_acc, 15);
    check("b2b_last_latency", out_cyc - acc_cyc, 2);
    // backpressure
    ir = 1'b0;
    fork
      begin
        send(1'b0, 8'h11, 4'd1, 8'h19);
        send(1'b0, 8'h22, 4'd2, 8'h33);
        send(1'b0, 8'h33, 4'd3, 8'h2A);
        send(1'b0, 8'h44, 4'd4, 8'h66);
      end
      begin
        repeat (3) @(posedge clk);
        #2;
        check("stall_ready", o_rdy, 0);
        check("stall_data0", od, 8'h19);
        repeat (2) @(posedge clk);
        #1;
        check("stall_data1", od, 8'h19);
        check("stall_tag", ot, 4'd1);
        ir = 1'b1;
      end
    join
    drain();
    // flush with beats in flight
    ir = 1'b0;
    send(1'b0, 8'h01, 4'd1, 8'h00, 1'b0);
    send(1'b0, 8'h02, 4'd2, 8'h00, 1'b0);
    clr = 1'b1; iv = 1'b1; id = 8'h55;
    #2;
    check("clr_ready", o_rdy, 0);
    @(posedge clk); #1;
    clr = 1'b0; iv = 1'b0; ir = 1'b1;
    check("clr_busy", busy, 0);
    check("clr_valid", ov, 0);
    repeat (4) @(posedge clk);
    #1;
    check("clr_no_output", ov, 0);
    // asynchronous reset mid-stream
    ir = 1'b0;
    send(1'b1, 8'h0F, 4'd6, 8'h00, 1'b0);
    send(1'b1, 8'hF0, 4'd7, 8'h00, 1'b0);
    iv = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("arst_valid", ov, 0);
    check("arst_busy", busy, 0);
    check("arst_ready", o_rdy, 1);
    check("arst_data", od, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; ir = 1'b1;
    send(1'b0, 8'h0B, 4'd7, 8'h0E); drain();
    check("arst_latency", out_cyc - acc_cyc, 2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
